// File: rtl/ava_scanout_if.sv
// ava_scanout_if: signal bundle between the display scan-out stage and its environment.
// vga_mode  : video mode from the register block (sampled by scan-out once per frame)
// vram_a/en : VRAM port-B read address/enable, vram_do returns one cycle after vram_en
// pram_a/en : PRAM port-B read address/enable, pram_do returns one cycle after pram_en
// vblank    : vertical blanking flag back to the register block
// vga_*     : RGB444 pixel colour and negative-polarity syncs
// master modport = scan-out side, slave modport = RAMs/register block/display side.
package ava_pkg;
    typedef enum logic [1:0] {MODE_OFF = 2'd0, MODE_IDX8 = 2'd1} vga_mode_t;
endpackage

interface ava_scanout_if #(
    parameter int VRAM_ADDR_WIDTH = 15,
    parameter int PRAM_ADDR_WIDTH = 8
);
    ava_pkg::vga_mode_t         vga_mode;
    logic [VRAM_ADDR_WIDTH-1:0] vram_a;
    logic                       vram_en;
    logic [31:0]                vram_do;
    logic [PRAM_ADDR_WIDTH-1:0] pram_a;
    logic                       pram_en;
    logic [31:0]                pram_do;
    logic                       vblank;
    logic [3:0]                 vga_r, vga_g, vga_b;
    logic                       vga_hs, vga_vs;

    modport master (
        input  vga_mode, vram_do, pram_do,
        output vram_a, vram_en, pram_a, pram_en, vblank, vga_r, vga_g, vga_b, vga_hs, vga_vs
    );
    modport slave (
        output vga_mode, vram_do, pram_do,
        input  vram_a, vram_en, pram_a, pram_en, vblank, vga_r, vga_g, vga_b, vga_hs, vga_vs
    );
endinterface

// File: rtl/ava_scanout.sv
// ava_scanout: 640x480@60 VGA scan-out showing a 320x240 indexed 8-bpp frame with 2x2 doubling.
// clk_i  : pixel clock (25.175 MHz nominal), rising edge
// rst_ni : asynchronous active-low reset
// bus    : ava_scanout_if master - vga_mode in, VRAM/PRAM port-B reads, vblank, RGB444 + syncs out
// Pipeline: stage 0 counters/VRAM fetch, stage 1 byte select/PRAM lookup, stage 2 colour register;
// syncs ride a matching 3-deep shift register so colour and syncs stay aligned.
module ava_scanout
    import ava_pkg::*;
#(
    parameter int VRAM_ADDR_WIDTH = 15,
    parameter int PRAM_ADDR_WIDTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ava_scanout_if.master bus
);
    logic [9:0]  h_q, h_d, v_q, v_d;
    vga_mode_t   mode_q, mode_cur;
    logic        frame_start, active, fetch, hs_raw, vs_raw;
    logic        act1_q, act2_q, fetch1_q;
    logic [1:0]  sel1_q;
    logic [31:0] word_q, word_src, addr_full;
    logic [7:0]  pix_idx;
    logic [11:0] rgb_q;
    logic [2:0]  hs_q, vs_q;
    logic        unused;

    assign frame_start = h_q == 10'd0 && v_q == 10'd0;
    // The mode is latched at the end of the frame-start cycle, so that cycle itself
    // must already see the incoming mode or pixel (0,0) would never be fetched.
    assign mode_cur    = frame_start ? bus.vga_mode : mode_q;
    assign active      = h_q < 10'd640 && v_q < 10'd480;
    assign h_d         = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
    assign v_d         = (h_q != 10'd799) ? v_q : (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
    assign hs_raw      = !(h_q >= 10'd656 && h_q <= 10'd751);
    assign vs_raw      = !(v_q >= 10'd490 && v_q <= 10'd491);

    // Both lines of a doubled pair address the same 80-word row: no line buffer.
    assign addr_full   = 32'(v_q >> 1) * 32'd80 + 32'(h_q >> 3);
    // Gated by rst_ni because mode_cur follows vga_mode combinationally at (0,0),
    // which is exactly where the counters sit while reset is held.
    assign fetch       = rst_ni && active && mode_cur == MODE_IDX8 && h_q[2:0] == 3'd0;
    assign bus.vram_en = fetch;
    assign bus.vram_a  = addr_full[VRAM_ADDR_WIDTH-1:0];

    // In the fetch-return cycle the word is still on vram_do, not yet in word_q.
    assign word_src    = fetch1_q ? bus.vram_do : word_q;
    assign pix_idx     = word_src[{sel1_q, 3'b000} +: 8];
    assign bus.pram_a  = PRAM_ADDR_WIDTH'(pix_idx);
    assign bus.pram_en = act1_q && mode_q == MODE_IDX8;

    assign {bus.vga_r, bus.vga_g, bus.vga_b} = rgb_q;
    assign bus.vga_hs  = hs_q[2];
    assign bus.vga_vs  = vs_q[2];
    assign bus.vblank  = v_q >= 10'd480;
    assign unused      = ^{bus.pram_do[31:12], addr_full[31:VRAM_ADDR_WIDTH]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q      <= '0;
            v_q      <= '0;
            mode_q   <= MODE_OFF;
            act1_q   <= 1'b0;
            act2_q   <= 1'b0;
            fetch1_q <= 1'b0;
            sel1_q   <= '0;
            word_q   <= '0;
            rgb_q    <= '0;
            hs_q     <= '1;
            vs_q     <= '1;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            if (frame_start) mode_q <= bus.vga_mode;
            act1_q   <= active;
            act2_q   <= act1_q;
            fetch1_q <= fetch;
            sel1_q   <= h_q[2:1];
            if (fetch1_q) word_q <= bus.vram_do;
            rgb_q    <= (act2_q && mode_q == MODE_IDX8) ? bus.pram_do[11:0] : 12'd0;
            hs_q     <= {hs_q[1:0], hs_raw};
            vs_q     <= {vs_q[1:0], vs_raw};
        end
    end
endmodule
